mig_init_sequencer: RTL and testbench

Sequences DDR bring-up downstream of the MIG reset hold timer. Drives the timer's enable, watches the MIG's `init_calib_complete` flag (synchronised locally), and releases the system-wide reset only after calibration has held stable. It bounds calibration with a timeout and re-runs the full hold/calibrate cycle a limited number of times before latching a failure flag.

---
 rtl/mig_init_sequencer.sv | 122 ++++++++++++
 tb/tb_mig_init_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_init_sequencer.sv
// DDR bring-up sequencer: enables the MIG reset hold timer, waits for a stable
// calibration, releases the system reset, and retries a bounded number of times.
module mig_init_sequencer #(
  parameter int CALIB_TIMEOUT_CYCLES = 10_000_000,
  parameter int TIMEOUT_WIDTH        = 24,
  parameter int SETTLE_CYCLES        = 16,
  parameter int RETRY_LOW_CYCLES     = 8,
  parameter int MAX_RETRIES          = 3,
  parameter int RETRY_WIDTH          = 2
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_N,
  input  logic                   i_Mig_Reset,
  input  logic                   i_Calib_Complete,
  output logic                   o_Timer_Enable,
  output logic                   o_System_Reset_N,
  output logic                   o_Calib_Failed,
  output logic [RETRY_WIDTH-1:0] o_Retry_Count
);

  localparam int SETTLE_WIDTH = $clog2(SETTLE_CYCLES) + 1;
  localparam int LOW_WIDTH    = $clog2(RETRY_LOW_CYCLES) + 1;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_WIDTH-1:0]  SETTLE_LAST  = SETTLE_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [LOW_WIDTH-1:0]     LOW_LAST     = LOW_WIDTH'(RETRY_LOW_CYCLES - 1);
  localparam logic [RETRY_WIDTH-1:0]   RETRY_MAX    = RETRY_WIDTH'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HOLD, S_WAIT_CALIB, S_SETTLE, S_RUN, S_RETRY, S_FAIL
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     w_retry_decide;
  logic                     w_retry_inc;
  logic                     r_calib_meta;
  logic                     r_calib_s;
  logic [TIMEOUT_WIDTH-1:0] r_timeout_cnt;
  logic [SETTLE_WIDTH-1:0]  r_settle_cnt;
  logic [LOW_WIDTH-1:0]     r_low_cnt;
  logic [RETRY_WIDTH-1:0]   r_retry_cnt;
  logic                     r_timer_enable;
  logic                     r_system_reset_n;
  logic                     r_calib_failed;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_next_state   = r_state;
    w_retry_decide = 1'b0;
    w_retry_inc    = 1'b0;
    unique case (r_state)
      S_IDLE:      w_next_state = S_WAIT_HOLD;
      S_WAIT_HOLD: if (i_Mig_Reset) w_next_state = S_WAIT_CALIB;
      S_WAIT_CALIB: begin
        if (!i_Mig_Reset)                     w_next_state   = S_WAIT_HOLD;
        else if (r_calib_s)                   w_next_state   = S_SETTLE;
        else if (r_timeout_cnt == TIMEOUT_LAST) w_retry_decide = 1'b1;
      end
      S_SETTLE: begin
        if (!i_Mig_Reset)                   w_next_state = S_WAIT_HOLD;
        else if (!r_calib_s)                w_next_state = S_WAIT_CALIB;
        else if (r_settle_cnt == SETTLE_LAST) w_next_state = S_RUN;
      end
      S_RUN:   if (!r_calib_s || !i_Mig_Reset) w_retry_decide = 1'b1;
      S_RETRY: if (r_low_cnt == LOW_LAST) w_next_state = S_WAIT_HOLD;
      S_FAIL:  w_next_state = S_FAIL;
      default: w_next_state = S_IDLE;
    endcase
    // A consumed retry restarts the whole hold/calibrate cycle; the last one latches FAIL.
    if (w_retry_decide) begin
      if (r_retry_cnt < RETRY_MAX) begin
        w_retry_inc  = 1'b1;
        w_next_state = S_RETRY;
      end else begin
        w_next_state = S_FAIL;
      end
    end
  end

  // NOTE: non-blocking assignments make every register update on an edge order-independent.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      r_state          <= S_IDLE;
      r_calib_meta     <= 1'b0;
      r_calib_s        <= 1'b0;
      r_timeout_cnt    <= '0;
      r_settle_cnt     <= '0;
      r_low_cnt        <= '0;
      r_retry_cnt      <= '0;
      r_timer_enable   <= 1'b0;
      r_system_reset_n <= 1'b0;
      r_calib_failed   <= 1'b0;
    end else begin
      r_calib_meta <= i_Calib_Complete;
      r_calib_s    <= r_calib_meta;
      r_state      <= w_next_state;

      // The timeout is held (not cleared) while in SETTLE so a calib glitch resumes it.
      if (r_state == S_WAIT_CALIB)     r_timeout_cnt <= r_timeout_cnt + TIMEOUT_WIDTH'(1);
      else if (r_state == S_WAIT_HOLD) r_timeout_cnt <= '0;

      if (r_state == S_SETTLE && r_calib_s) r_settle_cnt <= r_settle_cnt + SETTLE_WIDTH'(1);
      else                                  r_settle_cnt <= '0;

      if (r_state == S_RETRY) r_low_cnt <= r_low_cnt + LOW_WIDTH'(1);
      else                    r_low_cnt <= '0;

      if (w_retry_inc) r_retry_cnt <= r_retry_cnt + RETRY_WIDTH'(1);

      r_timer_enable   <= w_next_state inside {S_WAIT_HOLD, S_WAIT_CALIB, S_SETTLE, S_RUN};
      r_system_reset_n <= (w_next_state == S_RUN);
      r_calib_failed   <= (w_next_state == S_FAIL);
    end
  end

  assign o_Timer_Enable   = r_timer_enable;
  assign o_System_Reset_N = r_system_reset_n;
  assign o_Calib_Failed   = r_calib_failed;
  assign o_Retry_Count    = r_retry_cnt;

endmodule

// File: tb/tb_mig_init_sequencer.sv
// Bench for mig_init_sequencer: a hold-timer model plus a scoreboard of expected
// event latencies and output snapshots {enable, sys_rst_n, failed, retry_count}.
module tb_mig_init_sequencer;

  localparam int T_TIMEOUT = 100;
  localparam int T_SETTLE  = 4;
  localparam int T_LOW     = 8;
  localparam int T_MAXR    = 2;
  localparam int T_RW      = 2;
  localparam int T_HOLD    = 20;

  localparam int SEL_EN   = 0;
  localparam int SEL_SRST = 1;
  localparam int SEL_FAIL = 2;
  localparam int SEL_MIG  = 3;

  logic            i_Clock = 1'b0;
  logic            i_Reset_N = 1'b1;
  logic            i_Mig_Reset;
  logic            i_Calib_Complete = 1'b0;
  logic            o_Timer_Enable;
  logic            o_System_Reset_N;
  logic            o_Calib_Failed;
  logic [T_RW-1:0] o_Retry_Count;

  int n_tests = 0;
  int n_fail  = 0;
  int hold_cnt = 0;

  typedef struct {
    string      name;
    int         lat;
    logic [4:0] outs;
  } exp_t;
  exp_t sb[$];

  always #5 i_Clock = ~i_Clock;

  mig_init_sequencer #(
    .CALIB_TIMEOUT_CYCLES(T_TIMEOUT),
    .TIMEOUT_WIDTH       (8),
    .SETTLE_CYCLES       (T_SETTLE),
    .RETRY_LOW_CYCLES    (T_LOW),
    .MAX_RETRIES         (T_MAXR),
    .RETRY_WIDTH         (T_RW)
  ) dut (
    .i_Clock         (i_Clock),
    .i_Reset_N       (i_Reset_N),
    .i_Mig_Reset     (i_Mig_Reset),
    .i_Calib_Complete(i_Calib_Complete),
    .o_Timer_Enable  (o_Timer_Enable),
    .o_System_Reset_N(o_System_Reset_N),
    .o_Calib_Failed  (o_Calib_Failed),
    .o_Retry_Count   (o_Retry_Count)
  );

  // Hold-timer model: i_Mig_Reset rises after T_HOLD enabled cycles, drops when disabled.
  always @(posedge i_Clock) begin
    if (!o_Timer_Enable) begin
      hold_cnt    <= 0;
      i_Mig_Reset <= 1'b0;
    end else if (hold_cnt == T_HOLD - 1) begin
      i_Mig_Reset <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1;
    end
  end

  function automatic logic [4:0] outs();
    return {o_Timer_Enable, o_System_Reset_N, o_Calib_Failed, o_Retry_Count};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      SEL_EN:   return o_Timer_Enable;
      SEL_SRST: return o_System_Reset_N;
      SEL_FAIL: return o_Calib_Failed;
      default:  return i_Mig_Reset;
    endcase
  endfunction

  // Counts falling edges until the selected signal reaches val; lat = -1 on expiry.
  task automatic wait_event(input int sel, input logic val, input int budget,
                            output int lat, output logic [4:0] obs);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge i_Clock);
      if (sig(sel) === val) begin
        lat = k;
        break;
      end
    end
    obs = outs();
  endtask

  task automatic do_reset();
    @(negedge i_Clock);
    i_Reset_N        = 1'b0;
    i_Calib_Complete = 1'b0;
    repeat (3) @(negedge i_Clock);
    i_Reset_N = 1'b1;
  endtask

  task automatic test_reset();
    int lat;
    logic [4:0] obs;
    #1 i_Reset_N = 1'b0;
    #2;
    n_tests++;
    if (outs() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_async: outputs %b, expected 00000", outs());
    end
    repeat (3) @(negedge i_Clock);
    n_tests++;
    if (outs() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_held: outputs %b, expected 00000", outs());
    end
    i_Reset_N = 1'b1;
    #1;
    n_tests++;
    if (o_Timer_Enable !== 1'b0) begin
      n_fail++; $display("FAIL enable_before_edge: got %b, expected 0", o_Timer_Enable);
    end
    wait_event(SEL_EN, 1'b1, 10, lat, obs);
    n_tests++;
    if (lat < 1 || lat > 2) begin
      n_fail++; $display("FAIL enable_rise: latency %0d edges, expected 1..2", lat);
    end
  endtask

  task automatic test_nominal();
    int lat;
    logic [4:0] obs;
    exp_t e;
    wait_event(SEL_MIG, 1'b1, 100, lat, obs);
    repeat (10) @(negedge i_Clock);
    i_Calib_Complete = 1'b1;
    sb.push_back('{"nominal_release", T_SETTLE + 3, 5'b11000});
    wait_event(SEL_SRST, 1'b1, 50, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
  endtask

  task automatic test_run_loss();
    int lat;
    logic [4:0] obs;
    exp_t e;
    i_Calib_Complete = 1'b0;
    sb.push_back('{"run_loss", 3, 5'b00001});
    wait_event(SEL_SRST, 1'b0, 20, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
    sb.push_back('{"run_loss_retry_low", T_LOW, 5'b10001});
    wait_event(SEL_EN, 1'b1, 50, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
  endtask

  task automatic test_settle_glitch();
    int lat;
    logic [4:0] obs;
    exp_t e;
    do_reset();
    wait_event(SEL_MIG, 1'b1, 100, lat, obs);
    repeat (10) @(negedge i_Clock);
    i_Calib_Complete = 1'b1;
    repeat (2) @(negedge i_Clock);
    i_Calib_Complete = 1'b0;
    @(negedge i_Clock);
    i_Calib_Complete = 1'b1;
    sb.push_back('{"settle_glitch", T_SETTLE + 3, 5'b11000});
    wait_event(SEL_SRST, 1'b1, 50, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
  endtask

  task automatic test_timeout_retry();
    int lat;
    logic [4:0] obs;
    exp_t e;
    do_reset();
    wait_event(SEL_MIG, 1'b1, 100, lat, obs);
    // One-cycle calib pulse: one SETTLE cycle, timeout resumes from its held value.
    repeat (30) @(negedge i_Clock);
    i_Calib_Complete = 1'b1;
    @(negedge i_Clock);
    i_Calib_Complete = 1'b0;
    sb.push_back('{"timeout_after_blip", T_TIMEOUT + 2 - 31, 5'b00001});
    sb.push_back('{"retry_low_time", T_LOW, 5'b10001});
    sb.push_back('{"second_attempt_release", T_SETTLE + 3, 5'b11001});
    wait_event(SEL_EN, 1'b0, 300, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
    wait_event(SEL_EN, 1'b1, 50, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
    wait_event(SEL_MIG, 1'b1, 100, lat, obs);
    repeat (10) @(negedge i_Clock);
    i_Calib_Complete = 1'b1;
    wait_event(SEL_SRST, 1'b1, 50, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
  endtask

  task automatic test_exhaustion();
    int lat;
    int bad;
    logic [4:0] obs;
    exp_t e;
    do_reset();
    for (int a = 0; a <= T_MAXR; a++) begin
      wait_event(SEL_MIG, 1'b1, 200, lat, obs);
      if (a < T_MAXR) begin
        sb.push_back('{$sformatf("timeout_retry_%0d", a), T_TIMEOUT + 1, {3'b000, 2'(a + 1)}});
        wait_event(SEL_EN, 1'b0, 300, lat, obs);
      end else begin
        sb.push_back('{"timeout_fail", T_TIMEOUT + 1, 5'b00110});
        wait_event(SEL_FAIL, 1'b1, 300, lat, obs);
      end
      e = sb.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
      n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
    end
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge i_Clock);
      if (k == 500) i_Calib_Complete = 1'b1;
      if (outs() !== 5'b00110) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL fail_hold: %0d cycles left FAIL outputs, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_fail();
    int lat;
    logic [4:0] obs;
    @(negedge i_Clock);
    #2 i_Reset_N = 1'b0;
    #1;
    n_tests++;
    if (outs() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_mid_fail: outputs %b, expected 00000", outs());
    end
    i_Calib_Complete = 1'b0;
    @(negedge i_Clock);
    i_Reset_N = 1'b1;
    wait_event(SEL_EN, 1'b1, 10, lat, obs);
    n_tests++;
    if (lat < 1 || lat > 2 || obs !== 5'b10000) begin
      n_fail++; $display("FAIL restart_after_fail: latency %0d outputs %b, expected 1..2 and 10000", lat, obs);
    end
  endtask

  task automatic test_reset_mid_settle();
    int lat;
    logic [4:0] obs;
    exp_t e;
    wait_event(SEL_MIG, 1'b1, 100, lat, obs);
    repeat (5) @(negedge i_Clock);
    i_Calib_Complete = 1'b1;
    repeat (4) @(negedge i_Clock);
    n_tests++;
    if (outs() !== 5'b10000) begin
      n_fail++; $display("FAIL in_settle: outputs %b, expected 10000", outs());
    end
    #2 i_Reset_N = 1'b0;
    #1;
    n_tests++;
    if (outs() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_mid_settle: outputs %b, expected 00000", outs());
    end
    @(negedge i_Clock);
    i_Reset_N = 1'b1;
    wait_event(SEL_MIG, 1'b1, 100, lat, obs);
    sb.push_back('{"restart_release", T_SETTLE + 2, 5'b11000});
    wait_event(SEL_SRST, 1'b1, 50, lat, obs);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d, expected %0d", e.name, lat, e.lat); end
    n_tests++; if (obs !== e.outs) begin n_fail++; $display("FAIL %s outputs: got %b, expected %b", e.name, obs, e.outs); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_run_loss();
    test_settle_glitch();
    test_timeout_retry();
    test_exhaustion();
    test_reset_mid_fail();
    test_reset_mid_settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
